// File: rtl/arb_requester_pkg.sv
// Shared definitions for the arbiter requester block.
//   state_t    : transfer FSM states (IDLE, XFER, ACK)
//   NUM_CH     : number of requesting channels
//   LEN_W_DEF  : default width of a job length field
//   onehot_idx : index of the set bit in a one-hot channel vector
package arb_requester_pkg;

  localparam int NUM_CH    = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Only meaningful when v is one-hot; the caller qualifies that separately.
  function automatic logic [1:0] onehot_idx(input logic [NUM_CH-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Per-channel job-length FIFO.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : enqueue strobe, push_len is the job length to store
//   pop        : dequeue strobe (ignored when empty)
//   head       : length at the front of the queue
//   empty      : queue holds no jobs
//   overflow   : sticky, set when a push is dropped because the queue is full
module arb_req_fifo
  import arb_requester_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LEN_W-1:0] push_len,
  input  logic             pop,
  output logic [LEN_W-1:0] head,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push to a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_len;
  end

endmodule

// File: rtl/arb_requester.sv
// Four-channel job requester sitting in front of a round-robin arbiter.
// Each channel queues job lengths; a non-empty queue raises req. On a legal
// one-hot grant the owner streams `length` data beats, then pulses ack and
// retires the job.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : per-channel enqueue strobe; push_len[i*LEN_W +: LEN_W] is the length
//   req        : per-channel request to the arbiter (queue non-empty)
//   grant      : arbiter grant, combinational from req
//   ack        : one-cycle transfer-complete pulse
//   bus_valid  : data beat active; bus_owner is the beat's channel
//   bus_last   : final beat of the job
//   overflow   : sticky per-channel dropped-push flag
//   grant_err  : sticky flag for a grant that is not one-hot or not requested
module arb_requester
  import arb_requester_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH*LEN_W-1:0] push_len,
  output logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       grant,
  output logic                    ack,
  output logic                    bus_valid,
  output logic [1:0]              bus_owner,
  output logic                    bus_last,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    grant_err
);

  state_t            state, state_n;
  logic [1:0]        owner, owner_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic              err_set;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] empty;
  logic [LEN_W-1:0]  head [NUM_CH];

  logic              grant_onehot;
  logic              grant_legal;
  logic              grant_bad;
  logic [1:0]        sel;
  logic [LEN_W-1:0]  sel_len;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    arb_req_fifo #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .push_len (push_len[i*LEN_W +: LEN_W]),
      .pop      (pop[i]),
      .head     (head[i]),
      .empty    (empty[i]),
      .overflow (overflow[i])
    );
  end

  assign req = ~empty;

  assign grant_onehot = (grant != '0) && ((grant & (grant - NUM_CH'(1))) == '0);
  assign grant_legal  = grant_onehot && ((grant & ~req) == '0);
  assign grant_bad    = (grant != '0) && !grant_legal;
  assign sel          = onehot_idx(grant);
  assign sel_len      = head[sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      cnt       <= '0;
      grant_err <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      if (err_set) grant_err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    err_set = 1'b0;
    pop     = '0;
    case (state)
      IDLE: begin
        if (grant_legal) begin
          owner_n = sel;
          // A zero-length job still moves one beat.
          cnt_n   = (sel_len == '0) ? LEN_W'(1) : sel_len;
          state_n = XFER;
        end else if (grant_bad) begin
          err_set = 1'b1;
        end
      end
      XFER: begin
        cnt_n = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) state_n = ACK;
      end
      ACK: begin
        pop[owner] = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode directly from state so reset clears them immediately.
  assign ack       = (state == ACK);
  assign bus_valid = (state == XFER);
  assign bus_last  = (state == XFER) && (cnt == LEN_W'(1));
  assign bus_owner = owner;

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
  import arb_requester_pkg::*;

  localparam int LEN_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  push = '0;
  logic [15:0] push_len = '0;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        ack;
  logic        bus_valid;
  logic [1:0]  bus_owner;
  logic        bus_last;
  logic [3:0]  overflow;
  logic        grant_err;

  arb_requester #(.DEPTH(2), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_len  (push_len),
    .req       (req),
    .grant     (grant),
    .ack       (ack),
    .bus_valid (bus_valid),
    .bus_owner (bus_owner),
    .bus_last  (bus_last),
    .overflow  (overflow),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter partner, with an override for forcing arbitrary grants.
  logic       arb_en = 1'b0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = '0;
  logic [1:0] rr_last;
  logic [1:0] rr_idx;
  logic       rr_found;

  always @(posedge clk or negedge rst) begin
    if (!rst)     rr_last <= 2'd3;
    else if (ack) rr_last <= bus_owner;
  end

  always_comb begin
    grant    = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    if (force_en) begin
      grant = force_val;
    end else if (arb_en) begin
      for (int k = 1; k <= 4; k++) begin
        rr_idx = rr_last + 2'(k);
        if (!rr_found && req[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_found      = 1'b1;
        end
      end
    end
  end

  typedef struct {
    bit         is_ack;
    logic [1:0] owner;
    bit         last;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  beats_seen = 0;

  // Monitor: every beat or ack the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst && (bus_valid || ack)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got valid=%0b ack=%0b owner=%0d last=%0b, expected nothing",
                 bus_valid, ack, bus_owner, bus_last);
      end else begin
        e = exp_q.pop_front();
        if (e.is_ack) begin
          if (!(ack && !bus_valid && !bus_last)) begin
            errors++;
            $display("FAIL ack_event: got valid=%0b ack=%0b last=%0b, expected ack=1 valid=0 last=0",
                     bus_valid, ack, bus_last);
          end
        end else begin
          if (!(bus_valid && !ack && bus_owner == e.owner && bus_last == e.last)) begin
            errors++;
            $display("FAIL beat_event: got valid=%0b ack=%0b owner=%0d last=%0b, expected valid=1 owner=%0d last=%0b",
                     bus_valid, ack, bus_owner, bus_last, e.owner, e.last);
          end
        end
      end
      if (bus_valid) beats_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [3:0] mask, input logic [15:0] lens);
    push     = mask;
    push_len = lens;
    tick();
    push     = '0;
    push_len = '0;
  endtask

  task automatic exp_job(input int ch, input int len);
    ev_t e;
    int  n;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      e.is_ack = 1'b0;
      e.owner  = 2'(ch);
      e.last   = (i == n - 1);
      exp_q.push_back(e);
    end
    e.is_ack = 1'b1;
    e.owner  = 2'(ch);
    e.last   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(name, {req, ack, bus_valid, bus_owner, bus_last, overflow, grant_err}, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    int n;

    // Reset, then a single len=3 job on ch0.
    do_reset("reset_outputs");
    arb_en = 1'b1;
    exp_job(0, 3);
    do_push(4'b0001, 16'h0003);
    check("s1_req_after_push", req, 4'b0001);
    wait_drain("s1_drain", 20);
    check("s1_req_after_ack", req, 4'b0000);

    // All four channels, len=1, pushed together: serviced 0,1,2,3.
    do_reset("reset_before_s2");
    arb_en = 1'b1;
    for (int ch = 0; ch < 4; ch++) exp_job(ch, 1);
    do_push(4'b1111, 16'h1111);
    check("s2_req_after_push", req, 4'b1111);
    wait_drain("s2_drain", 40);
    check("s2_req_after_acks", req, 4'b0000);

    // Three pushes to ch2 with no grant: third one dropped.
    arb_en = 1'b0;
    do_push(4'b0100, 16'h0100);
    do_push(4'b0100, 16'h0200);
    do_push(4'b0100, 16'h0300);
    check("s3_overflow", overflow, 4'b0100);
    check("s3_req_full", req, 4'b0100);
    exp_job(2, 1);
    exp_job(2, 2);
    arb_en = 1'b1;
    wait_drain("s3_drain", 40);
    check("s3_req_after", req, 4'b0000);
    check("s3_overflow_sticky", overflow, 4'b0100);

    // Illegal (non one-hot) grant in IDLE, then a legal one.
    arb_en = 1'b0;
    do_push(4'b0010, 16'h0020);
    force_val = 4'b0011;
    force_en  = 1'b1;
    tick();
    force_en  = 1'b0;
    check("s4_grant_err", grant_err, 1'b1);
    check("s4_no_valid", bus_valid, 1'b0);
    tick();
    check("s4_still_idle", {bus_valid, ack, req}, {1'b0, 1'b0, 4'b0010});
    exp_job(1, 2);
    arb_en = 1'b1;
    wait_drain("s4_drain", 20);
    check("s4_grant_err_sticky", grant_err, 1'b1);

    // Reset during beat 2 of a len=5 job on ch3, with a ch0 job queued behind it.
    begin
      ev_t e;
      e.is_ack = 1'b0;
      e.owner  = 2'd3;
      e.last   = 1'b0;
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    base = beats_seen;
    do_push(4'b1000, 16'h5000);
    do_push(4'b0001, 16'h0002);
    n = 0;
    while (beats_seen < base + 2 && n < 30) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("s5_reached_beat2", beats_seen - base, 2);
    rst = 1'b0;
    #1;
    check("s5_outputs_in_reset", {req, ack, bus_valid, bus_owner, bus_last, overflow, grant_err}, 32'h0);
    check("s5_no_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("s5_fifos_empty", req, 4'b0000);

    // First push right after reset release: len=0 on ch1 is one beat.
    exp_job(1, 0);
    do_push(4'b0010, 16'h0000);
    check("s6_req_after_push", req, 4'b0010);
    wait_drain("s6_drain", 20);
    check("s6_req_after_ack", req, 4'b0000);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
